i2s_rx_array: RTL and testbench



---
 rtl/i2s_rx_array.sv | 128 ++++++++++++
 tb/tb_i2s_rx_array.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_array.sv
// rtl/i2s_rx_array.sv - multi-lane I2S receiver sharing one clk/ws.
// Optional frame_err pulse on short slots is enabled by I2S_RX_FRAME_ERR_EN.
module i2s_rx_array #(
  parameter int N_LANES     = 4,
  parameter int SAMPLE_BITS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ws,
  input  logic [N_LANES-1:0]             sd,
  output logic [N_LANES*SAMPLE_BITS-1:0] left_data,
  output logic [N_LANES*SAMPLE_BITS-1:0] right_data,
  output logic                           valid,
  output logic                           frame_err
);

  localparam int CW = $clog2(SAMPLE_BITS + 1);
  localparam int DW = N_LANES * SAMPLE_BITS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SYNC  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] SKIP  = 2'd3;

  logic [1:0]    state;
  logic          prev_ws;
  logic          chan;
  logic          left_ok;
  logic          emit_pend;
  logic [CW-1:0] count;
  logic [DW-1:0] shift_q;
  logic [DW-1:0] shift_d;
  logic [DW-1:0] left_hold;
  logic          edge_det;
  logic          last_bit;
  logic          slot_done;
  logic          short_slot;

  always_comb begin
    shift_d = '0;
    for (int i = 0; i < N_LANES; i++) begin
      shift_d[i*SAMPLE_BITS +: SAMPLE_BITS] = {shift_q[i*SAMPLE_BITS +: SAMPLE_BITS-1], sd[i]};
    end
    edge_det   = (ws != prev_ws);
    last_bit   = (count == CW'(SAMPLE_BITS - 1));
    slot_done  = (state == SHIFT) && last_bit;
    // The edge cycle's bit still counts, so a slot ending exactly on the edge is complete.
    short_slot = (state == SHIFT) && edge_det && !last_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prev_ws    <= 1'b0;
      chan       <= 1'b0;
      left_ok    <= 1'b0;
      emit_pend  <= 1'b0;
      count      <= '0;
      shift_q    <= '0;
      left_hold  <= '0;
      left_data  <= '0;
      right_data <= '0;
      valid      <= 1'b0;
    end else begin
      prev_ws   <= ws;
      valid     <= 1'b0;
      emit_pend <= 1'b0;
      // Right word sits in shift_q for exactly one cycle after completion.
      if (emit_pend) begin
        left_data  <= left_hold;
        right_data <= shift_q;
        valid      <= 1'b1;
      end
      case (state)
        IDLE: state <= SYNC;
        SYNC: begin
          if (edge_det) begin
            state <= SHIFT;
            chan  <= ws;
            count <= '0;
          end
        end
        SHIFT: begin
          shift_q <= shift_d;
          count   <= count + CW'(1);
          if (slot_done) begin
            state <= SKIP;
            if (!chan) begin
              left_hold <= shift_d;
              left_ok   <= 1'b1;
            end else if (left_ok) begin
              emit_pend <= 1'b1;
              left_ok   <= 1'b0;
            end
          end else if (short_slot && !chan) begin
            left_ok <= 1'b0;
          end
          if (edge_det) begin
            state <= SHIFT;
            chan  <= ws;
            count <= '0;
          end
        end
        SKIP: begin
          if (edge_det) begin
            state <= SHIFT;
            chan  <= ws;
            count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef I2S_RX_FRAME_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= short_slot;
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx_array.sv
// tb/tb_i2s_rx_array.sv - scoreboard bench for i2s_rx_array.
// Slot-level reference model feeds expectation queues; a monitor checks valid/frame_err/data.
module tb_i2s_rx_array;

  localparam int N  = 4;
  localparam int SB = 8;
  localparam int W  = N * SB;
`ifdef I2S_RX_FRAME_ERR_EN
  localparam bit FE_EN = 1'b1;
`else
  localparam bit FE_EN = 1'b0;
`endif

  typedef struct {
    int           cyc;
    logic [W-1:0] l;
    logic [W-1:0] r;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         ws;
  logic [N-1:0] sd;
  logic [W-1:0] left_data;
  logic [W-1:0] right_data;
  logic         valid;
  logic         frame_err;

  i2s_rx_array #(.N_LANES(N), .SAMPLE_BITS(SB)) dut (
    .clk(clk), .reset(reset), .ws(ws), .sd(sd),
    .left_data(left_data), .right_data(right_data),
    .valid(valid), .frame_err(frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int valid_seen = 0;
  int fe_seen = 0;
  int kcyc = 0;
  exp_t vq[$];
  int   feq[$];
  logic [W-1:0] exp_l = '0;
  logic [W-1:0] exp_r = '0;

  // reference model state: slot bits kept as a list of per-cycle lane vectors
  int           m_phase = 0;
  logic         m_prev = 1'b0;
  logic         m_ch = 1'b0;
  logic         m_done = 1'b0;
  logic         m_lok = 1'b0;
  logic [W-1:0] m_hold = '0;
  logic [N-1:0] m_bits[$];
  logic [N-1:0] lag_bits = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] assemble();
    logic [W-1:0] word;
    word = '0;
    for (int j = 0; j < SB; j++)
      for (int i = 0; i < N; i++)
        word[i*SB + SB-1-j] = m_bits[j][i];
    return word;
  endfunction

  task automatic open_slot(input logic w);
    m_ch = w;
    m_done = 1'b0;
    m_bits.delete();
    m_phase = 2;
  endtask

  task automatic model_step(input int k, input logic r, input logic w, input logic [N-1:0] s);
    logic e;
    logic [W-1:0] word;
    exp_t x;
    if (r) begin
      m_phase = 0; m_prev = 1'b0; m_lok = 1'b0; m_done = 1'b0; m_hold = '0;
      m_bits.delete();
      while (vq.size() > 0 && vq[vq.size()-1].cyc >= k) x = vq.pop_back();
      while (feq.size() > 0 && feq[feq.size()-1] >= k) e = 1'(feq.pop_back());
      return;
    end
    if (m_phase == 0) begin
      m_prev = w;
      m_phase = 1;
      return;
    end
    e = (w != m_prev);
    m_prev = w;
    if (m_phase == 1) begin
      if (e) open_slot(w);
      return;
    end
    if (!m_done) begin
      m_bits.push_back(s);
      if (m_bits.size() == SB) begin
        m_done = 1'b1;
        word = assemble();
        if (!m_ch) begin
          m_hold = word;
          m_lok = 1'b1;
        end else if (m_lok) begin
          x.cyc = k + 1; x.l = m_hold; x.r = word;
          vq.push_back(x);
          m_lok = 1'b0;
        end
      end else if (e) begin
        if (FE_EN) feq.push_back(k + 1);
        if (!m_ch) m_lok = 1'b0;
      end
    end
    if (e) open_slot(w);
  endtask

  task automatic step(input logic r, input logic w, input logic [N-1:0] s);
    reset = r; ws = w; sd = s;
    kcyc++;
    model_step(kcyc, r, w, s);
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic w, input logic [N-1:0] b);
    step(1'b0, w, lag_bits);
    lag_bits = b;
  endtask

  task automatic slot(input logic ch, input int len, input logic [W-1:0] words);
    logic [N-1:0] b;
    for (int j = 0; j < len; j++) begin
      b = N'($urandom);
      if (j < SB)
        for (int i = 0; i < N; i++) b[i] = words[i*SB + SB-1-j];
      drv(ch, b);
    end
  endtask

  task automatic rst_cycles(input int n, input logic w);
    for (int j = 0; j < n; j++) step(1'b1, w, N'($urandom));
    lag_bits = N'($urandom);
  endtask

  initial begin : monitor
    int   mcyc;
    logic r;
    exp_t e;
    int   f;
    mcyc = 0;
    forever begin
      @(posedge clk);
      mcyc++;
      r = reset;
      @(negedge clk);
      if (r) begin exp_l = '0; exp_r = '0; end
      if (valid === 1'b1) begin
        valid_seen++;
        if (vq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_valid: valid=1 at cycle %0d, none expected", mcyc);
        end else begin
          e = vq.pop_front();
          chk("valid_cycle", 64'(mcyc), 64'(e.cyc));
          chk("left_data", 64'(left_data), 64'(e.l));
          chk("right_data", 64'(right_data), 64'(e.r));
          exp_l = e.l; exp_r = e.r;
        end
      end else begin
        chk("hold_left", 64'(left_data), 64'(exp_l));
        chk("hold_right", 64'(right_data), 64'(exp_r));
      end
      while (vq.size() > 0 && vq[0].cyc < mcyc) begin
        e = vq.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL missed_valid: valid=0 at cycle %0d, required 1", e.cyc);
      end
      if (frame_err === 1'b1) begin
        fe_seen++;
        if (feq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_frame_err: frame_err=1 at cycle %0d, required 0", mcyc);
        end else begin
          f = feq.pop_front();
          chk("frame_err_cycle", 64'(mcyc), 64'(f));
        end
      end
      while (feq.size() > 0 && feq[0] < mcyc) begin
        f = feq.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL missed_frame_err: frame_err=0 at cycle %0d, required 1", f);
      end
    end
  end

  initial begin : driver
    int v0, f0, rr, len;
    logic ch;
    reset = 1'b1; ws = 1'b1; sd = '0;

    // full 16-bit slots, distinct per-lane words
    rst_cycles(3, 1'b1);
    for (int j = 0; j < 3; j++) drv(1'b1, N'($urandom));
    v0 = valid_seen; f0 = fe_seen;
    slot(1'b0, 16, 32'hA3A2A1A0);
    slot(1'b1, 16, 32'h53525150);
    slot(1'b0, 16, W'($urandom));
    chk("frame16_valid_count", 64'(valid_seen - v0), 64'd1);
    chk("frame16_left", 64'(left_data), 64'hA3A2A1A0);
    chk("frame16_right", 64'(right_data), 64'h53525150);

    // slots exactly SB bits long: edge lands on the LSB cycle
    v0 = valid_seen; f0 = fe_seen;
    slot(1'b1, SB, W'($urandom));
    slot(1'b0, SB, 32'hFFFFFFFF);
    slot(1'b1, SB, 32'h01010101);
    slot(1'b0, SB, W'($urandom));
    chk("exact_valid_count", 64'(valid_seen - v0), 64'd2);
    chk("exact_left", 64'(left_data), 64'hFFFFFFFF);
    chk("exact_right", 64'(right_data), 64'h01010101);
    chk("exact_no_frame_err", 64'(fe_seen - f0), 64'd0);

    // short left slot, then full right (no valid), then a good frame
    slot(1'b1, 16, W'($urandom));
    v0 = valid_seen; f0 = fe_seen;
    slot(1'b0, 5, W'($urandom));
    slot(1'b1, 16, W'($urandom));
    chk("short_no_valid", 64'(valid_seen - v0), 64'd0);
    chk("short_frame_err", 64'(fe_seen - f0), 64'(FE_EN));
    slot(1'b0, 16, 32'h0F1E2D3C);
    slot(1'b1, 16, 32'hC3B2A190);
    slot(1'b0, 16, W'($urandom));
    chk("short_recover_valid", 64'(valid_seen - v0), 64'd1);
    chk("short_recover_left", 64'(left_data), 64'h0F1E2D3C);
    chk("short_recover_right", 64'(right_data), 64'hC3B2A190);

    // reset at bit 4 of a right slot
    slot(1'b1, 16, W'($urandom));
    slot(1'b0, 16, W'($urandom));
    slot(1'b1, 4, W'($urandom));
    rst_cycles(2, 1'b0);
    v0 = valid_seen;
    chk("rst_left_zero", 64'(left_data), 64'd0);
    chk("rst_right_zero", 64'(right_data), 64'd0);
    slot(1'b0, 3, W'($urandom));
    slot(1'b1, 16, W'($urandom));
    chk("rst_no_early_valid", 64'(valid_seen - v0), 64'd0);
    slot(1'b0, 16, 32'h11223344);
    slot(1'b1, 16, 32'h55667788);
    slot(1'b0, 16, W'($urandom));
    chk("rst_first_valid", 64'(valid_seen - v0), 64'd1);
    chk("rst_left", 64'(left_data), 64'h11223344);

    // ws high at reset release: needs a real 1->0 then 0->1
    rst_cycles(2, 1'b1);
    v0 = valid_seen;
    slot(1'b1, 12, W'($urandom));
    chk("wshigh_no_valid", 64'(valid_seen - v0), 64'd0);
    slot(1'b0, 16, 32'h89ABCDEF);
    slot(1'b1, 16, 32'h76543210);
    slot(1'b0, 16, W'($urandom));
    chk("wshigh_valid", 64'(valid_seen - v0), 64'd1);
    chk("wshigh_right", 64'(right_data), 64'h76543210);

    // randomized slot lengths, data and occasional resets
    ch = 1'b1;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 14) == 0) rst_cycles($urandom_range(1, 2), 1'($urandom_range(0, 1)));
      rr = $urandom_range(0, 9);
      if (rr < 2)      len = $urandom_range(1, SB - 1);
      else if (rr < 4) len = SB;
      else             len = $urandom_range(SB + 1, 2 * SB);
      slot(ch, len, W'($urandom));
      ch = ~ch;
    end
    slot(ch, 2 * SB, W'($urandom));
    for (int j = 0; j < 4; j++) drv(ch, N'($urandom));

    @(negedge clk);
    @(negedge clk);
    chk("pending_valid_left", 64'(vq.size()), 64'd0);
    chk("pending_frame_err_left", 64'(feq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
